// File: rtl/lsu_mem_ctrl_if.sv
// Bundles the pipeline-side request/response handshake and the 64-bit
// data-memory bus of the load/store sequencer into one interface.
// 'slave' is the controller's view; 'master' is the view of whatever
// drives the pipeline requests and models the memory.
interface lsu_mem_ctrl_if;
  // Pipeline request
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [2:0]  req_load_type;
  logic [1:0]  req_store_size;
  // Pipeline response
  logic        resp_valid;
  logic [63:0] resp_data;
  logic [1:0]  resp_err;
  // Memory bus request
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_req_wen;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  // Memory bus response
  logic        mem_resp_valid;
  logic [63:0] mem_resp_rdata;

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_load_type, req_store_size,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output req_ready, resp_valid, resp_data, resp_err,
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask
  );

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_load_type, req_store_size,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  req_ready, resp_valid, resp_data, resp_err,
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer between the MEM stage and the 64-bit data bus.
// One transaction in flight: accept -> alignment check -> one aligned
// 8-byte bus request -> wait (with watchdog) -> one-cycle result pulse.
// Every output is a register or a decode of the state register.
module lsu_mem_ctrl #(
  parameter int unsigned TIMEOUT = 255  // cycles allowed in WAIT; 0 disables
) (
  input logic           clk,
  input logic           rst_n,
  lsu_mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  // log2 of the load access size in bytes; type 000 behaves as ld
  function automatic logic [1:0] load_size(input logic [2:0] lt);
    case (lt)
      3'b001, 3'b101: load_size = 2'd0;
      3'b010, 3'b110: load_size = 2'd1;
      3'b011, 3'b111: load_size = 2'd2;
      default:        load_size = 2'd3;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [2:0] a);
    case (sz)
      2'd0:    is_misaligned = 1'b0;
      2'd1:    is_misaligned = a[0];
      2'd2:    is_misaligned = |a[1:0];
      default: is_misaligned = |a;
    endcase
  endfunction

  function automatic logic [7:0] store_mask(input logic [1:0] sz, input logic [2:0] a);
    case (sz)
      2'd0:    store_mask = 8'b0000_0001 << a;
      2'd1:    store_mask = 8'b0000_0011 << a;
      2'd2:    store_mask = 8'b0000_1111 << a;
      default: store_mask = 8'hFF;
    endcase
  endfunction

  // Shift the addressed bytes down to bit 0, then zero/sign extend
  function automatic logic [63:0] extract_load(input logic [63:0] rdata,
                                               input logic [2:0]  a,
                                               input logic [2:0]  lt);
    logic [63:0] d;
    d = rdata >> {a, 3'b000};
    case (lt)
      3'b001:  extract_load = {{56{d[7]}},  d[7:0]};
      3'b010:  extract_load = {{48{d[15]}}, d[15:0]};
      3'b011:  extract_load = {{32{d[31]}}, d[31:0]};
      3'b101:  extract_load = {56'd0, d[7:0]};
      3'b110:  extract_load = {48'd0, d[15:0]};
      3'b111:  extract_load = {32'd0, d[31:0]};
      default: extract_load = d;
    endcase
  endfunction

  state_e      r_state, w_state_nxt;
  logic        r_wen;
  logic [63:0] r_addr;
  logic [2:0]  r_load_type;
  logic [63:0] r_wdata;
  logic [7:0]  r_wmask;
  logic [63:0] r_resp_data;
  logic [1:0]  r_err;
  logic [15:0] r_cnt;

  logic        w_accept;
  logic [1:0]  w_size;
  logic        w_misaligned;
  logic        w_timeout;
  logic        w_resp_load;
  logic        w_take_rdata;
  logic [1:0]  w_err_nxt;

  assign w_accept     = bus.req_valid && (r_state == S_IDLE);
  assign w_size       = bus.req_wen ? bus.req_store_size : load_size(bus.req_load_type);
  assign w_misaligned = is_misaligned(w_size, bus.req_addr[2:0]);
  assign w_timeout    = (TIMEOUT != 0) && (32'(r_cnt) >= TIMEOUT);

  // State register
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the always blocks evaluate in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode plus the "load the response registers" strobe
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_resp_load  = 1'b0;
    w_take_rdata = 1'b0;
    w_err_nxt    = ERR_OK;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_misaligned) begin
            w_state_nxt = S_RESP;
            w_resp_load = 1'b1;
            w_err_nxt   = ERR_MISALIGN;
          end else begin
            w_state_nxt = S_REQ;
          end
        end
      end
      S_REQ: begin
        // A response arriving alongside mem_req_ready is not for us: ignored
        if (bus.mem_req_ready) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus.mem_resp_valid) begin
          w_state_nxt  = S_RESP;
          w_resp_load  = 1'b1;
          w_take_rdata = 1'b1;
        end else if (w_timeout) begin
          w_state_nxt = S_RESP;
          w_resp_load = 1'b1;
          w_err_nxt   = ERR_TIMEOUT;
        end
      end
      default: w_state_nxt = S_IDLE;  // S_RESP lasts one cycle
    endcase
  end

  // Capture the request at acceptance; bus fields stay stable until the next accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wen       <= 1'b0;
      r_addr      <= '0;
      r_load_type <= '0;
      r_wdata     <= '0;
      r_wmask     <= '0;
    end else if (w_accept) begin
      r_wen       <= bus.req_wen;
      r_addr      <= bus.req_addr;
      r_load_type <= bus.req_load_type;
      r_wdata     <= bus.req_wdata << {bus.req_addr[2:0], 3'b000};
      r_wmask     <= bus.req_wen ? store_mask(bus.req_store_size, bus.req_addr[2:0]) : 8'h00;
    end
  end

  // Response registers: data is only non-zero for a successful load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_data <= '0;
      r_err       <= ERR_OK;
    end else if (w_resp_load) begin
      r_err       <= w_err_nxt;
      r_resp_data <= (w_take_rdata && !r_wen)
                     ? extract_load(bus.mem_resp_rdata, r_addr[2:0], r_load_type)
                     : 64'd0;
    end
  end

  // Watchdog: cleared on bus handshake, counts (saturating) every WAIT cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     r_cnt <= '0;
    else if (r_state == S_REQ && bus.mem_req_ready) r_cnt <= '0;
    else if (r_state == S_WAIT && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
  end

  assign bus.req_ready     = (r_state == S_IDLE);
  assign bus.resp_valid    = (r_state == S_RESP);
  assign bus.resp_data     = r_resp_data;
  assign bus.resp_err      = r_err;
  assign bus.mem_req_valid = (r_state == S_REQ);
  assign bus.mem_req_addr  = {r_addr[63:3], 3'b000};
  assign bus.mem_req_wen   = r_wen;
  assign bus.mem_req_wdata = r_wdata;
  assign bus.mem_req_wmask = r_wmask;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed scenarios followed by
// randomized transactions, all checked against a byte-level reference model.
module tb_lsu_mem_ctrl;

  localparam int TB_TIMEOUT = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  lsu_mem_ctrl_if u_if ();

  lsu_mem_ctrl #(.TIMEOUT(TB_TIMEOUT)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_time_limit: simulation did not finish within the time limit");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic int acc_bytes(input logic wen, input logic [2:0] lt, input logic [1:0] ss);
    if (wen) return 1 << ss;
    case (lt)
      3'b001, 3'b101: return 1;
      3'b010, 3'b110: return 2;
      3'b011, 3'b111: return 4;
      default:        return 8;
    endcase
  endfunction

  function automatic logic [63:0] exp_load(input logic [63:0] rdata, input int a, input logic [2:0] lt);
    int          n;
    bit          sgn;
    logic [63:0] v;
    n   = acc_bytes(1'b0, lt, 2'b00);
    sgn = (lt == 3'b001) || (lt == 3'b010) || (lt == 3'b011);
    v   = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = rdata[8*(a+i) +: 8];
    if (sgn && v[8*n-1])
      for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [7:0] exp_mask(input int a, input int n);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < n; i++) m[a+i] = 1'b1;
    return m;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},     u_if.req_ready,     64'd1);
    check({tag, "_resp_valid"},    u_if.resp_valid,    64'd0);
    check({tag, "_resp_data"},     u_if.resp_data,     64'd0);
    check({tag, "_resp_err"},      u_if.resp_err,      64'd0);
    check({tag, "_mem_req_valid"}, u_if.mem_req_valid, 64'd0);
    check({tag, "_mem_req_wen"},   u_if.mem_req_wen,   64'd0);
    check({tag, "_mem_req_addr"},  u_if.mem_req_addr,  64'd0);
    check({tag, "_mem_req_wdata"}, u_if.mem_req_wdata, 64'd0);
    check({tag, "_mem_req_wmask"}, u_if.mem_req_wmask, 64'd0);
  endtask

  // One full transaction, driven and sampled on falling edges.
  // stall: cycles mem_req_ready is held low; delay: WAIT cycles before the
  // response; withhold: never respond; resp_in_req: junk response alongside
  // mem_req_ready, which must be ignored.
  task automatic run_txn(input string tag, input logic wen, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [2:0] lt, input logic [1:0] ss,
                         input logic [63:0] rdata, input int stall, input int delay,
                         input bit withhold, input bit resp_in_req);
    int a;
    int n;
    bit misal;
    a     = int'(addr[2:0]);
    n     = acc_bytes(wen, lt, ss);
    misal = (a % n) != 0;

    check({tag, "_ready_before"}, u_if.req_ready, 64'd1);
    u_if.req_valid      = 1'b1;
    u_if.req_wen        = wen;
    u_if.req_addr       = addr;
    u_if.req_wdata      = wdata;
    u_if.req_load_type  = lt;
    u_if.req_store_size = ss;
    @(negedge clk);
    u_if.req_valid = 1'b0;
    u_if.req_addr  = ~addr;   // accepted fields must not track the inputs
    u_if.req_wdata = ~wdata;
    check({tag, "_ready_after_accept"}, u_if.req_ready, 64'd0);

    if (misal) begin
      check({tag, "_mis_resp_valid"}, u_if.resp_valid,    64'd1);
      check({tag, "_mis_err"},        u_if.resp_err,      64'd1);
      check({tag, "_mis_data"},       u_if.resp_data,     64'd0);
      check({tag, "_mis_no_bus"},     u_if.mem_req_valid, 64'd0);
    end else begin
      for (int i = 0; i <= stall; i++) begin
        check({tag, "_mreq_valid"}, u_if.mem_req_valid, 64'd1);
        check({tag, "_mreq_addr"},  u_if.mem_req_addr,  addr & ~64'd7);
        check({tag, "_mreq_wen"},   u_if.mem_req_wen,   64'(wen));
        if (wen) begin
          check({tag, "_mreq_wmask"}, u_if.mem_req_wmask, 64'(exp_mask(a, n)));
          check({tag, "_mreq_wdata"}, u_if.mem_req_wdata, wdata << (8 * a));
        end
        check({tag, "_no_early_resp"}, u_if.resp_valid, 64'd0);
        if (i == stall) begin
          u_if.mem_req_ready = 1'b1;
          if (resp_in_req) begin
            u_if.mem_resp_valid = 1'b1;
            u_if.mem_resp_rdata = ~rdata;
          end
        end
        @(negedge clk);
      end
      u_if.mem_req_ready  = 1'b0;
      u_if.mem_resp_valid = 1'b0;
      check({tag, "_mreq_dropped"}, u_if.mem_req_valid, 64'd0);

      if (withhold) begin
        for (int i = 0; i <= TB_TIMEOUT; i++) begin
          check({tag, "_wait_no_resp"}, u_if.resp_valid, 64'd0);
          @(negedge clk);
        end
        check({tag, "_to_resp_valid"}, u_if.resp_valid, 64'd1);
        check({tag, "_to_err"},        u_if.resp_err,   64'd2);
        check({tag, "_to_data"},       u_if.resp_data,  64'd0);
      end else begin
        for (int i = 0; i < delay; i++) begin
          check({tag, "_wait_no_resp"}, u_if.resp_valid, 64'd0);
          @(negedge clk);
        end
        u_if.mem_resp_valid = 1'b1;
        u_if.mem_resp_rdata = rdata;
        @(negedge clk);
        u_if.mem_resp_valid = 1'b0;
        u_if.mem_resp_rdata = {$urandom, $urandom};
        check({tag, "_resp_valid"}, u_if.resp_valid, 64'd1);
        check({tag, "_resp_err"},   u_if.resp_err,   64'd0);
        check({tag, "_resp_data"},  u_if.resp_data,  wen ? 64'd0 : exp_load(rdata, a, lt));
      end
    end

    @(negedge clk);
    check({tag, "_resp_one_cycle"}, u_if.resp_valid, 64'd0);
    check({tag, "_ready_again"},    u_if.req_ready,  64'd1);
  endtask

  initial begin
    logic        r_wen;
    logic [63:0] r_addr;
    logic [2:0]  r_lt;
    logic [1:0]  r_ss;
    int          r_n;

    n_checks = 0;
    n_pass   = 0;
    rst_n               = 1'b0;
    u_if.req_valid      = 1'b0;
    u_if.req_wen        = 1'b0;
    u_if.req_addr       = '0;
    u_if.req_wdata      = '0;
    u_if.req_load_type  = '0;
    u_if.req_store_size = '0;
    u_if.mem_req_ready  = 1'b0;
    u_if.mem_resp_valid = 1'b0;
    u_if.mem_resp_rdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_rst");

    // lb sign extension, best-case latency
    run_txn("lb_sext", 1'b0, 64'h1003, 64'd0, 3'b001, 2'b00, 64'h0000_0000_8000_0000, 0, 0, 1'b0, 1'b0);
    // lhu / lw on one word
    run_txn("lhu", 1'b0, 64'h2006, 64'd0, 3'b110, 2'b00, 64'h1234_5678_9ABC_DEF0, 0, 0, 1'b0, 1'b0);
    run_txn("lw_hi", 1'b0, 64'h2004, 64'd0, 3'b011, 2'b00, 64'h1234_5678_9ABC_DEF0, 0, 1, 1'b0, 1'b0);
    run_txn("lw_lo", 1'b0, 64'h2000, 64'd0, 3'b011, 2'b00, 64'h1234_5678_9ABC_DEF0, 0, 0, 1'b0, 1'b0);
    // Store half
    run_txn("sh", 1'b1, 64'h3002, 64'hABCD, 3'b000, 2'b01, 64'hDEAD_BEEF_DEAD_BEEF, 0, 0, 1'b0, 1'b0);
    // Misaligned word load
    run_txn("lw_mis", 1'b0, 64'h4002, 64'd0, 3'b011, 2'b00, 64'd0, 0, 0, 1'b0, 1'b0);
    // Type 000 load behaves as ld; response exactly at the watchdog limit wins
    run_txn("ld000", 1'b0, 64'h4008, 64'd0, 3'b000, 2'b00, 64'h8765_4321_0FED_CBA9, 0, TB_TIMEOUT, 1'b0, 1'b0);

    // Watchdog, then a late response in IDLE must be ignored
    run_txn("ld_timeout", 1'b0, 64'h5000, 64'd0, 3'b100, 2'b00, 64'd0, 0, 0, 1'b1, 1'b0);
    u_if.mem_resp_valid = 1'b1;
    u_if.mem_resp_rdata = 64'h1111_2222_3333_4444;
    @(negedge clk);
    u_if.mem_resp_valid = 1'b0;
    check("late_resp_ignored", u_if.resp_valid, 64'd0);
    check("late_resp_ready",   u_if.req_ready,  64'd1);
    @(negedge clk);
    check("late_resp_ignored2", u_if.resp_valid, 64'd0);

    // Backpressure: mem_req_ready low for 3 cycles, plus an ignored response in REQ
    run_txn("sw_stall", 1'b1, 64'h6004, 64'hCAFE_F00D, 3'b000, 2'b10, 64'd0, 3, 2, 1'b0, 1'b1);

    // Reset pulse during WAIT
    u_if.req_valid     = 1'b1;
    u_if.req_wen       = 1'b0;
    u_if.req_addr      = 64'h7000;
    u_if.req_load_type = 3'b100;
    @(negedge clk);
    u_if.req_valid     = 1'b0;
    u_if.mem_req_ready = 1'b1;
    @(negedge clk);
    u_if.mem_req_ready = 1'b0;
    check("rst_mid_in_wait", u_if.mem_req_valid, 64'd0);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    u_if.mem_resp_valid = 1'b1;
    @(negedge clk);
    u_if.mem_resp_valid = 1'b0;
    check("rst_dropped_no_resp", u_if.resp_valid, 64'd0);
    @(negedge clk);
    check("rst_dropped_no_resp2", u_if.resp_valid, 64'd0);
    run_txn("after_rst", 1'b0, 64'h7010, 64'd0, 3'b010, 2'b00, 64'h0000_0000_0000_F123, 0, 0, 1'b0, 1'b0);

    // Randomized transactions
    for (int t = 0; t < 40; t++) begin
      r_wen  = 1'($urandom_range(0, 1));
      r_lt   = 3'($urandom_range(0, 7));
      r_ss   = 2'($urandom_range(0, 3));
      r_addr = {$urandom, $urandom};
      r_n    = acc_bytes(r_wen, r_lt, r_ss);
      if ($urandom_range(0, 3) != 0) r_addr = r_addr & ~64'(r_n - 1);
      run_txn($sformatf("rnd%0d", t), r_wen, r_addr, {$urandom, $urandom}, r_lt, r_ss,
              {$urandom, $urandom}, int'($urandom_range(0, 3)), int'($urandom_range(0, TB_TIMEOUT)),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
